// File: rtl/irq_arbiter_pkg.sv
// Shared types and helpers for the interrupt arbiter.
`default_nettype none

package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int              MAX_SRC  = 8;
    localparam logic [MAX_SRC-1:0] MASK_RST = '1;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_arbiter_rr_picker.sv
// Combinational picker: first set request bit at or above ptr, wrapping.
`default_nettype none

module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    int             j;
    logic [IDW-1:0] jj;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            jj = IDW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// Latches peripheral interrupt requests and grants one at a time to the CPU.
`default_nettype none

module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DATA_W      = 4,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        srcReq,
    input  logic [NUM_SRC*DATA_W-1:0] srcData,
    input  logic                      cfgWe,
    input  logic [NUM_SRC-1:0]        cfgMask,
    input  logic                      cfgClrOverrun,
    input  logic                      irqAck,
    output logic                      irq,
    output logic [id_w(NUM_SRC)-1:0]  irqId,
    output logic [DATA_W-1:0]         irqData,
    output logic [NUM_SRC-1:0]        pending,
    output logic [NUM_SRC-1:0]        overrun,
    output logic [NUM_SRC-1:0]        mask
);

    localparam int IDW = id_w(NUM_SRC);

    state_t                           state_q;
    logic                             irq_q;
    logic [IDW-1:0]                   irqId_q;
    logic [DATA_W-1:0]                irqData_q;
    logic [IDW-1:0]                   rr_q;
    logic [NUM_SRC-1:0]               pending_q, pending_d;
    logic [NUM_SRC-1:0]               overrun_q, overrun_d;
    logic [NUM_SRC-1:0]               mask_q;
    logic [NUM_SRC-1:0][DATA_W-1:0]   data_q, data_d;
    logic [NUM_SRC-1:0]               ack_hit;

    logic                             win_found;
    logic [IDW-1:0]                   win_idx;
    logic [IDW-1:0]                   pick_ptr;

    assign pick_ptr = ROUND_ROBIN ? rr_q : '0;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_picker (
        .req   (pending_q & mask_q),
        .ptr   (pick_ptr),
        .found (win_found),
        .idx   (win_idx)
    );

    // A new request on the source being acknowledged keeps it pending without an overrun.
    always_comb begin
        ack_hit   = '0;
        pending_d = pending_q;
        overrun_d = overrun_q & ~{NUM_SRC{cfgClrOverrun}};
        data_d    = data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_hit[i] = (state_q == GRANT) && irqAck && (irqId_q == IDW'(i));
            if (ack_hit[i]) pending_d[i] = 1'b0;
            if (srcReq[i]) begin
                pending_d[i] = 1'b1;
                data_d[i]    = srcData[i*DATA_W +: DATA_W];
                if (pending_q[i] && !ack_hit[i]) overrun_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
            data_q    <= '0;
            mask_q    <= MASK_RST[NUM_SRC-1:0];
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            if (cfgWe) mask_q <= cfgMask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            irqId_q   <= '0;
            irqData_q <= '0;
            rr_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        irqId_q   <= win_idx;
                        irqData_q <= data_q[win_idx];
                        irq_q     <= 1'b1;
                        rr_q      <= (win_idx == IDW'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    if (irqAck) begin
                        irq_q   <= 1'b0;
                        state_q <= HOLDOFF;
                    end
                end
                HOLDOFF: state_q <= IDLE;
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq     = irq_q;
    assign irqId   = irqId_q;
    assign irqData = irqData_q;
    assign pending = pending_q;
    assign overrun = overrun_q;
    assign mask    = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// Directed scoreboard bench for irq_arbiter in round-robin and fixed-priority modes.
`default_nettype none

module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  srcReq = '0;
    logic [15:0] srcData = '0;
    logic        cfgWe = 1'b0;
    logic [3:0]  cfgMask = '0;
    logic        cfgClrOverrun = 1'b0;
    logic        irqAck = 1'b0;

    logic        irq_a, irq_b;
    logic [1:0]  id_a, id_b;
    logic [3:0]  data_a, data_b;
    logic [3:0]  pend_a, pend_b, ovr_a, ovr_b, mask_a, mask_b;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    irq_arbiter #(.NUM_SRC(4), .DATA_W(4), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .srcReq(srcReq), .srcData(srcData),
        .cfgWe(cfgWe), .cfgMask(cfgMask), .cfgClrOverrun(cfgClrOverrun),
        .irqAck(irqAck), .irq(irq_a), .irqId(id_a), .irqData(data_a),
        .pending(pend_a), .overrun(ovr_a), .mask(mask_a)
    );

    irq_arbiter #(.NUM_SRC(4), .DATA_W(4), .ROUND_ROBIN(1'b0)) dut_fx (
        .clk(clk), .rst(rst), .srcReq(srcReq), .srcData(srcData),
        .cfgWe(cfgWe), .cfgMask(cfgMask), .cfgClrOverrun(cfgClrOverrun),
        .irqAck(irqAck), .irq(irq_b), .irqId(id_b), .irqData(data_b),
        .pending(pend_b), .overrun(ovr_b), .mask(mask_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input logic [3:0] req, input logic [15:0] data);
        srcReq  = req;
        srcData = data;
        tick();
        srcReq  = '0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        cfgWe   = 1'b1;
        cfgMask = m;
        tick();
        cfgWe   = 1'b0;
    endtask

    task automatic ack();
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for the round-robin instance to raise irq, then pops and compares.
    task automatic check_grant(input string tag);
        exp_t e;
        int   waited = 0;
        while (!irq_a && waited < 10) begin
            tick();
            waited++;
        end
        chk({tag, "_irq"}, {31'd0, irq_a}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_id"},   {30'd0, id_a},   {30'd0, e.id});
            chk({tag, "_data"}, {28'd0, data_a}, {28'd0, e.data});
        end else begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
    endtask

    initial begin
        exp_t e;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_irq",  {31'd0, irq_a}, 32'd0);
        chk("rst_id",   {30'd0, id_a},  32'd0);
        chk("rst_data", {28'd0, data_a}, 32'd0);
        chk("rst_pend", {28'd0, pend_a}, 32'd0);
        chk("rst_ovr",  {28'd0, ovr_a},  32'd0);
        chk("rst_mask", {28'd0, mask_a}, 32'hF);

        // Single source, latency and holdoff.
        e = '{id: 2'd1, data: 4'h7}; sb.push_back(e);
        pulse_req(4'b0010, 16'h0070);
        chk("t1_pend", {28'd0, pend_a}, 32'h2);
        chk("t1_irq_early", {31'd0, irq_a}, 32'd0);
        tick();
        chk("t1_irq_now", {31'd0, irq_a}, 32'd1);
        check_grant("t1");
        ack();
        chk("t1_ack_irq",  {31'd0, irq_a}, 32'd0);
        chk("t1_ack_pend", {28'd0, pend_a}, 32'h0);
        tick();
        chk("t1_hold_irq", {31'd0, irq_a}, 32'd0);
        tick();
        chk("t1_idle_irq", {31'd0, irq_a}, 32'd0);

        // Rotation between sources 0 and 2; fixed instance always grants 0.
        do_reset();
        pulse_req(4'b0101, 16'h0503);
        for (int g = 0; g < 6; g++) begin
            e = (g % 2 == 0) ? '{id: 2'd0, data: 4'h3} : '{id: 2'd2, data: 4'h5};
            sb.push_back(e);
            check_grant($sformatf("rr%0d", g));
            chk($sformatf("fx%0d_irq", g), {31'd0, irq_b}, 32'd1);
            chk($sformatf("fx%0d_id", g),  {30'd0, id_b},  32'd0);
            ack();
            pulse_req(4'b0101, 16'h0503);
        end

        // Masked source latches but is not granted until unmasked.
        do_reset();
        write_mask(4'b1110);
        chk("t3_mask", {28'd0, mask_a}, 32'hE);
        pulse_req(4'b0001, 16'h000A);
        tick();
        chk("t3_pend", {28'd0, pend_a}, 32'h1);
        chk("t3_irq_masked", {31'd0, irq_a}, 32'd0);
        e = '{id: 2'd0, data: 4'hA}; sb.push_back(e);
        write_mask(4'b1111);
        chk("t3_irq_mask_edge", {31'd0, irq_a}, 32'd0);
        tick();
        chk("t3_irq_2edges", {31'd0, irq_a}, 32'd1);
        check_grant("t3");
        ack();
        tick();

        // Overrun: second pulse before grant wins the data.
        write_mask(4'b0111);
        pulse_req(4'b1000, 16'h2000);
        pulse_req(4'b1000, 16'h9000);
        chk("t4_ovr", {28'd0, ovr_a}, 32'h8);
        chk("t4_irq_masked", {31'd0, irq_a}, 32'd0);
        e = '{id: 2'd3, data: 4'h9}; sb.push_back(e);
        write_mask(4'b1111);
        tick();
        check_grant("t4");
        cfgClrOverrun = 1'b1;
        tick();
        cfgClrOverrun = 1'b0;
        chk("t4_clr", {28'd0, ovr_a}, 32'h0);
        ack();
        tick();
        // Back-to-back pulses: grant issued between them carries the first payload.
        e = '{id: 2'd3, data: 4'h2}; sb.push_back(e);
        pulse_req(4'b1000, 16'h2000);
        pulse_req(4'b1000, 16'h9000);
        check_grant("t4b");
        chk("t4b_ovr", {28'd0, ovr_a}, 32'h8);
        // Clear and new overrun together: the set wins.
        cfgClrOverrun = 1'b1;
        pulse_req(4'b1000, 16'h5000);
        cfgClrOverrun = 1'b0;
        chk("t4b_clr_vs_set", {28'd0, ovr_a}, 32'h8);
        chk("t4b_data_frozen", {28'd0, data_a}, 32'h2);
        ack();

        // Request on the granted source together with its ack.
        do_reset();
        pulse_req(4'b0010, 16'h0010);
        tick();
        chk("t5_irq", {31'd0, irq_a}, 32'd1);
        srcReq  = 4'b0010;
        srcData = 16'h00C0;
        ack();
        srcReq  = '0;
        chk("t5_pend", {28'd0, pend_a}, 32'h2);
        chk("t5_ovr",  {28'd0, ovr_a},  32'h0);
        chk("t5_irq_low", {31'd0, irq_a}, 32'd0);
        tick();
        chk("t5_hold_low", {31'd0, irq_a}, 32'd0);
        e = '{id: 2'd1, data: 4'hC}; sb.push_back(e);
        tick();
        check_grant("t5");

        // Mask change does not revoke; async reset mid-grant clears everything.
        pulse_req(4'b0010, 16'h0040);
        chk("t6_ovr", {28'd0, ovr_a}, 32'h2);
        write_mask(4'b0000);
        chk("t6_irq_kept", {31'd0, irq_a}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_irq",  {31'd0, irq_a}, 32'd0);
        chk("t6_rst_pend", {28'd0, pend_a}, 32'h0);
        chk("t6_rst_ovr",  {28'd0, ovr_a},  32'h0);
        chk("t6_rst_mask", {28'd0, mask_a}, 32'hF);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
